// File: rtl/seq_det_sched.sv
// Two-requester round-robin frame scheduler for a shared serial sequence detector.
// Clears the detector, shifts the granted frame out MSB-first and counts z hits per frame.
module seq_det_sched #(
  parameter int FRAME_W = 8,
  parameter int CNT_W   = 4,
  parameter int DET_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic               req1,
  input  logic [FRAME_W-1:0] data0,
  input  logic [FRAME_W-1:0] data1,
  output logic               gnt0,
  output logic               gnt1,
  output logic               det_w,
  output logic               det_rst,
  input  logic               det_z,
  output logic               busy,
  output logic               done,
  output logic               done_id,
  output logic [CNT_W-1:0]   hit_cnt,
  output logic [2:0]         dbg_state
);

  // Handshake: a requester holds reqN high with dataN stable; the frame is captured
  // on the IDLE edge that sees it, and gntN pulses in the following (CLR) cycle.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_SHIFT = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int PW = $clog2(FRAME_W + DET_LAT + 1);
  localparam logic [PW-1:0]    LAST_SHIFT = PW'(FRAME_W - 1);
  localparam logic [PW-1:0]    LAST_DRAIN = PW'(DET_LAT - 1);
  localparam logic [PW-1:0]    FIRST_HIT  = PW'(DET_LAT);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PW-1:0]      r_idx;
  logic [FRAME_W-1:0] r_sr;
  logic               r_id;
  logic               r_last;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_hit_cnt;
  logic               r_done_id;
  logic               r_rst_q;

  logic               w_req_any;
  logic               w_pick1;
  logic               w_sample;
  logic [CNT_W-1:0]   w_cnt_nxt;

  assign w_req_any = req0 | req1;
  // With both requesting, the one not served last wins.
  assign w_pick1   = req1 & (~req0 | ~r_last);
  // z lags w by DET_LAT, so the window skips the first DET_LAT shift cycles and covers the drain.
  assign w_sample  = ((r_state == S_SHIFT) && (r_idx >= FIRST_HIT)) || (r_state == S_DRAIN);
  assign w_cnt_nxt = (w_sample && det_z && (r_cnt != CNT_MAX)) ? r_cnt + CNT_W'(1) : r_cnt;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_req_any) w_state_nxt = S_CLR;
      S_CLR:   w_state_nxt = S_SHIFT;
      S_SHIFT: if (r_idx == LAST_SHIFT) w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_idx == LAST_DRAIN) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx     <= '0;
      r_sr      <= '0;
      r_id      <= 1'b0;
      r_last    <= 1'b1;
      r_cnt     <= '0;
      r_hit_cnt <= '0;
      r_done_id <= 1'b0;
      r_rst_q   <= 1'b1;
    end else begin
      r_rst_q <= 1'b0;
      if (r_state != w_state_nxt) r_idx <= '0;
      else                        r_idx <= r_idx + PW'(1);
      case (r_state)
        S_IDLE: begin
          if (w_req_any) begin
            r_sr   <= w_pick1 ? data1 : data0;
            r_id   <= w_pick1;
            r_last <= w_pick1;
          end
        end
        S_CLR: r_cnt <= '0;
        S_SHIFT: begin
          r_sr  <= {r_sr[FRAME_W-2:0], 1'b0};
          r_cnt <= w_cnt_nxt;
        end
        S_DRAIN: begin
          r_cnt <= w_cnt_nxt;
          if (r_idx == LAST_DRAIN) begin
            r_hit_cnt <= w_cnt_nxt;
            r_done_id <= r_id;
          end
        end
        default: ;
      endcase
    end
  end

  // Detector reset is also held for the cycle after a scheduler reset.
  assign det_rst   = (r_state == S_CLR) | r_rst_q;
  assign det_w     = (r_state == S_SHIFT) & r_sr[FRAME_W-1];
  assign gnt0      = (r_state == S_CLR) & ~r_id;
  assign gnt1      = (r_state == S_CLR) &  r_id;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign done_id   = r_done_id;
  assign hit_cnt   = r_hit_cnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_seq_det_sched.sv
// Directed + randomized bench for seq_det_sched with a behavioural detector (z = w delayed by DET_LAT).
module tb_seq_det_sched;

  localparam int FW = 8;
  localparam int L  = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [FW-1:0] data0 = '0, data1 = '0;
  logic          gnt0, gnt1, det_w, det_rst, det_z, busy, done, done_id;
  logic [3:0]    hit_cnt;
  logic [2:0]    dbg_state;
  logic          z_force_en = 1'b0, z_force_val = 1'b0;
  logic          z_q;

  seq_det_sched #(.FRAME_W(FW), .CNT_W(4), .DET_LAT(L)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .data0(data0), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1), .det_w(det_w), .det_rst(det_rst), .det_z(det_z),
    .busy(busy), .done(done), .done_id(done_id), .hit_cnt(hit_cnt), .dbg_state(dbg_state)
  );

  always @(posedge clk) z_q <= det_rst ? 1'b0 : det_w;
  assign det_z = z_force_en ? z_force_val : z_q;

  // Second instance: longer detector latency and a 2-bit saturating counter.
  logic          a_req0 = 1'b0, a_req1 = 1'b0;
  logic [FW-1:0] a_data0 = '0, a_data1 = '0;
  logic          a_gnt0, a_gnt1, a_det_w, a_det_rst, a_det_z, a_busy, a_done, a_done_id;
  logic [1:0]    a_hit_cnt;
  logic [2:0]    a_dbg_state;
  logic [2:0]    a_pipe;

  seq_det_sched #(.FRAME_W(FW), .CNT_W(2), .DET_LAT(3)) u_alt (
    .clk(clk), .rst(rst), .req0(a_req0), .req1(a_req1), .data0(a_data0), .data1(a_data1),
    .gnt0(a_gnt0), .gnt1(a_gnt1), .det_w(a_det_w), .det_rst(a_det_rst), .det_z(a_det_z),
    .busy(a_busy), .done(a_done), .done_id(a_done_id), .hit_cnt(a_hit_cnt), .dbg_state(a_dbg_state)
  );

  always @(posedge clk) a_pipe <= a_det_rst ? 3'b000 : {a_pipe[1:0], a_det_w};
  assign a_det_z = a_pipe[2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_det_rst", det_rst, 1);
    chk("rst_det_w", det_w, 0);
    chk("rst_gnt", {gnt1, gnt0}, 0);
    chk("rst_done", done, 0);
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_done_id", done_id, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_det_rst", det_rst, 0);
  endtask

  // mode 0: detector model drives z. mode 1: z taken from mask, bit p = cycle p after gnt
  // (p=0 CLR, 1..FW shift, FW+1..FW+L drain, FW+L+1 done); z is also 1 in IDLE.
  task automatic run_frame(input string tag, input logic exp_id, input logic [FW-1:0] data,
                           input int mode, input logic [15:0] mask, input logic drop,
                           output int wait_cyc);
    logic got;
    int   exp_hits;
    got = 1'b0;
    wait_cyc = 0;
    z_force_en  = (mode != 0);
    z_force_val = (mode != 0);
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      wait_cyc++;
      if (gnt0 | gnt1) got = 1'b1;
    end
    chk({tag, "_gnt_seen"}, got, 1);
    if (!got) return;
    chk({tag, "_gnt1"}, gnt1, exp_id);
    chk({tag, "_gnt0"}, gnt0, !exp_id);
    chk({tag, "_clr_det_rst"}, det_rst, 1);
    chk({tag, "_busy"}, busy, 1);
    if (drop) begin
      if (exp_id) req1 = 1'b0;
      else        req0 = 1'b0;
    end
    if (mode != 0) z_force_val = mask[0];
    for (int i = 0; i < FW; i++) begin
      @(negedge clk);
      chk({tag, "_det_w"}, det_w, data[FW-1-i]);
      if (i == 0) chk({tag, "_shift_det_rst"}, det_rst, 0);
      if (mode != 0) z_force_val = mask[1+i];
    end
    for (int i = 0; i < L; i++) begin
      @(negedge clk);
      chk({tag, "_drain_det_w"}, det_w, 0);
      if (mode != 0) z_force_val = mask[FW+1+i];
    end
    @(negedge clk);
    if (mode == 0) exp_hits = $countones(data);
    else begin
      exp_hits = 0;
      for (int p = 1 + L; p <= FW + L; p++) exp_hits += int'(mask[p]);
    end
    if (exp_hits > 15) exp_hits = 15;
    chk({tag, "_done"}, done, 1);
    chk({tag, "_done_id"}, done_id, exp_id);
    chk({tag, "_hit_cnt"}, hit_cnt, exp_hits);
    if (mode != 0) z_force_val = 1'b1;
  endtask

  initial begin
    int   w;
    logic got, seen;
    logic p0, p1, lst, win;
    int   n;

    // Single frame, requester 0, then the detector-pattern frame.
    do_reset();
    req0 = 1'b1; data0 = 8'hB5;
    run_frame("t1", 1'b0, 8'hB5, 0, 16'h0, 1'b1, w);
    chk("t1_latency", w, 1);
    req0 = 1'b1; data0 = 8'b10111100;
    run_frame("integ", 1'b0, 8'b10111100, 0, 16'h0, 1'b1, w);

    // Simultaneous requests held high: alternate with one IDLE between frames.
    do_reset();
    req0 = 1'b1; req1 = 1'b1; data0 = 8'hFF; data1 = 8'h01;
    run_frame("rr_a", 1'b0, 8'hFF, 0, 16'h0, 1'b0, w);
    run_frame("rr_b", 1'b1, 8'h01, 0, 16'h0, 1'b0, w);
    chk("rr_b_gap", w, 2);
    run_frame("rr_c", 1'b0, 8'hFF, 0, 16'h0, 1'b0, w);
    chk("rr_c_gap", w, 2);
    req0 = 1'b0; req1 = 1'b0;

    // Reset in the 4th shift cycle of 8'hAA; a req0 pulse during the frame must be lost.
    req1 = 1'b1; data1 = 8'hAA;
    got = 1'b0;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      if (gnt1) got = 1'b1;
    end
    chk("mid_gnt1_seen", got, 1);
    req1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 1) req0 = 1'b1;
      if (i == 2) req0 = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_busy", busy, 0);
    chk("mid_det_rst", det_rst, 1);
    chk("mid_hit_cnt", hit_cnt, 0);
    chk("mid_done", done, 0);
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done | gnt0 | gnt1) seen = 1'b1;
    end
    chk("mid_no_done_or_gnt", seen, 0);
    req0 = 1'b1; req1 = 1'b1; data0 = 8'h3C; data1 = 8'h81;
    run_frame("post_rst_both", 1'b0, 8'h3C, 0, 16'h0, 1'b1, w);
    run_frame("post_rst_req1", 1'b1, 8'h81, 0, 16'h0, 1'b1, w);

    // Hit window edges with forced z.
    req0 = 1'b1; data0 = 8'h00;
    run_frame("win_early", 1'b0, 8'h00, 1, 16'h0403, 1'b1, w);
    req0 = 1'b1;
    run_frame("win_drain", 1'b0, 8'h00, 1, 16'h0200, 1'b1, w);
    req0 = 1'b1;
    run_frame("win_first", 1'b0, 8'h00, 1, 16'h0004, 1'b1, w);

    // Random requests/data/z against a round-robin + window-count model.
    p0 = 1'b0; p1 = 1'b0; lst = 1'b0;
    for (int it = 0; it < 20; it++) begin
      if (!p0 && ($urandom_range(0, 1) == 1)) begin p0 = 1'b1; data0 = FW'($urandom); end
      if (!p1 && ($urandom_range(0, 1) == 1)) begin p1 = 1'b1; data1 = FW'($urandom); end
      if (!p0 && !p1) begin p0 = 1'b1; data0 = FW'($urandom); end
      req0 = p0; req1 = p1;
      win = (p0 && p1) ? !lst : p1;
      run_frame("rand", win, win ? data1 : data0, $urandom_range(0, 1),
                16'($urandom), 1'b1, w);
      if (win) p1 = 1'b0; else p0 = 1'b0;
      lst = win;
    end
    req0 = 1'b0; req1 = 1'b0; z_force_en = 1'b0;

    // DET_LAT=3, CNT_W=2: done 12 cycles after gnt, count saturates at 3.
    a_req0 = 1'b1; a_data0 = 8'hFF;
    got = 1'b0;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      if (a_gnt0) got = 1'b1;
    end
    chk("alt_gnt0_seen", got, 1);
    a_req0 = 1'b0;
    n = 0; got = 1'b0;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      n++;
      if (a_done) got = 1'b1;
    end
    chk("alt_done_seen", got, 1);
    chk("alt_done_latency", n, FW + 3 + 1);
    chk("alt_hit_cnt_sat", a_hit_cnt, 3);
    chk("alt_done_id", a_done_id, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
